// File: rtl/onehot_step_sequencer_if.sv
// Handshake and step-output bundle between the multdiv control FSM and the step sequencer.
// Latency: none; this is wiring only.
// Backpressure: stall, driven by the master, holds the slave on its current step.
// Optional: `STEP_DESCEND_EN adds the descend request bit.
// Ports: master drives start/last_idx/stall/abort(/descend) and observes the step outputs;
//        slave (the sequencer) is the mirror image.
interface onehot_step_sequencer_if #(
    parameter int SEL_W = 5
);
    localparam int OUT_W = 2**SEL_W;

    logic             start;
    logic [SEL_W-1:0] last_idx;
    logic             stall;
    logic             abort;
`ifdef STEP_DESCEND_EN
    logic             descend;
`endif
    logic [OUT_W-1:0] step_onehot;
    logic [SEL_W-1:0] step_idx;
    logic             first;
    logic             last;
    logic             busy;
    logic             done;

`ifdef STEP_DESCEND_EN
    modport master (
        output start, last_idx, stall, abort, descend,
        input  step_onehot, step_idx, first, last, busy, done
    );
    modport slave (
        input  start, last_idx, stall, abort, descend,
        output step_onehot, step_idx, first, last, busy, done
    );
`else
    modport master (
        output start, last_idx, stall, abort,
        input  step_onehot, step_idx, first, last, busy, done
    );
    modport slave (
        input  start, last_idx, stall, abort,
        output step_onehot, step_idx, first, last, busy, done
    );
`endif
endinterface

// File: rtl/onehot_step_sequencer.sv
// Registered step generator: walks a SEL_W-bit index to a latched last step and one-hot decodes it.
// Latency: start accepted at edge t -> step k visible after edge t+k; done pulses after edge t+last+1.
// Backpressure: stall holds the current step (and delays done); abort returns to IDLE with no done.
// Optional: `STEP_DESCEND_EN adds bus.descend; when set at start the index runs from last down to 0.
// Ports: clock (rising edge), reset (synchronous, active-high),
//        bus (slave modport): start/last_idx/stall/abort(/descend) in,
//        step_onehot/step_idx/first/last/busy/done out.
module onehot_step_sequencer #(
    parameter int SEL_W = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    onehot_step_sequencer_if.slave   bus
);
    localparam int OUT_W = 2**SEL_W;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] STEP_ONE = {{(SEL_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_step;
    logic [SEL_W-1:0] r_last;
    logic             r_done;

    logic [SEL_W-1:0] w_begin_idx;  // index of the first step of the running sequence
    logic [SEL_W-1:0] w_end_idx;    // index of the final step of the running sequence
    logic [SEL_W-1:0] w_step_nxt;   // index of the following step
    logic             w_at_end;
    logic             w_accept;

`ifdef STEP_DESCEND_EN
    logic r_desc;

    always_comb begin
        w_begin_idx = r_desc ? r_last : '0;
        w_end_idx   = r_desc ? '0 : r_last;
        w_step_nxt  = r_desc ? (r_step - STEP_ONE) : (r_step + STEP_ONE);
    end
`else
    always_comb begin
        w_begin_idx = '0;
        w_end_idx   = r_last;
        w_step_nxt  = r_step + STEP_ONE;
    end
`endif

    assign w_at_end = (r_step == w_end_idx);
    assign w_accept = (r_state == IDLE) && bus.start;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort outranks stall and the normal advance.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    w_state_nxt = IDLE;
                end else if (!bus.stall && w_at_end) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Step counter, latched bound and done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_step <= '0;
            r_last <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_last <= bus.last_idx;
`ifdef STEP_DESCEND_EN
                r_step <= bus.descend ? bus.last_idx : '0;
`else
                r_step <= '0;
`endif
            end else if (r_state == RUN) begin
                if (bus.abort) begin
                    r_step <= '0;
                end else if (!bus.stall) begin
                    if (w_at_end) begin
                        r_step <= '0;
                        r_done <= 1'b1;
                    end else begin
                        r_step <= w_step_nxt;
                    end
                end
            end
        end
    end

`ifdef STEP_DESCEND_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            r_desc <= 1'b0;
        end else if (w_accept) begin
            r_desc <= bus.descend;
        end
    end
`endif

    // Outputs come from registers only, so nothing combinational reaches them from the inputs.
    always_comb begin
        bus.step_onehot = '0;
        bus.busy        = (r_state == RUN);
        bus.step_idx    = r_step;
        bus.done        = r_done;
        bus.first       = 1'b0;
        bus.last        = 1'b0;
        if (r_state == RUN) begin
            bus.step_onehot[r_step] = 1'b1;
            bus.first               = (r_step == w_begin_idx);
            bus.last                = w_at_end;
        end
    end

    // OUT_W exists to document the decode width; reference it so width intent stays checked.
    if (OUT_W != (1 << SEL_W)) begin : g_bad_width
        $error("OUT_W must equal 2**SEL_W");
    end

endmodule

// File: tb/tb_onehot_step_sequencer.sv
module tb_onehot_step_sequencer;
    localparam int SEL_W = 5;

    logic clock = 1'b0;
    logic reset;
    int   total_cnt = 0;
    int   pass_cnt  = 0;
    int   busy_cnt  = 0;
    logic [31:0] exp_oh;

    onehot_step_sequencer_if #(.SEL_W(SEL_W)) bus ();

    onehot_step_sequencer #(.SEL_W(SEL_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
        if (bus.busy === 1'b1) busy_cnt++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.last_idx = '0;
        bus.stall    = 1'b0;
        bus.abort    = 1'b0;
`ifdef STEP_DESCEND_EN
        bus.descend  = 1'b0;
`endif
        tick();
        tick();
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_onehot", bus.step_onehot, 0);
        check("rst_idx", bus.step_idx, 0);
        check("rst_first", bus.first, 0);
        check("rst_last", bus.last, 0);
        reset = 1'b0;
        tick();
        check("idle_busy", bus.busy, 0);

        // Full 32-step sweep.
        bus.start = 1'b1; bus.last_idx = 5'd31;
        tick();
        bus.start = 1'b0;
        check("sweep0_onehot", bus.step_onehot, 32'h0000_0001);
        check("sweep0_first", bus.first, 1);
        check("sweep0_last", bus.last, 0);
        for (int k = 1; k < 32; k++) begin
            tick();
            exp_oh = 32'h1 << k;
            check("sweep_onehot", bus.step_onehot, exp_oh);
            check("sweep_first", bus.first, 0);
            check("sweep_last", bus.last, (k == 31) ? 32'd1 : 32'd0);
            check("sweep_done", bus.done, 0);
        end
        tick();
        check("sweep_done_pulse", bus.done, 1);
        check("sweep_end_busy", bus.busy, 0);
        check("sweep_end_onehot", bus.step_onehot, 0);
        tick();
        check("sweep_done_clr", bus.done, 0);

        // Single-step sequence.
        bus.start = 1'b1; bus.last_idx = 5'd0;
        tick();
        bus.start = 1'b0;
        check("single_busy", bus.busy, 1);
        check("single_onehot", bus.step_onehot, 32'h1);
        check("single_first", bus.first, 1);
        check("single_last", bus.last, 1);
        tick();
        check("single_done", bus.done, 1);
        check("single_idle", bus.busy, 0);
        tick();
        check("single_done_clr", bus.done, 0);

        // Stall three cycles at step 4 of an 8-step run.
        busy_cnt = 0;
        bus.start = 1'b1; bus.last_idx = 5'd7;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        check("stall_idx4", bus.step_idx, 4);
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_hold", bus.step_onehot, 32'h10);
            check("stall_busy", bus.busy, 1);
        end
        bus.stall = 1'b0;
        repeat (3) tick();
        check("stall_idx7", bus.step_idx, 7);
        check("stall_last", bus.last, 1);
        check("stall_no_early_done", bus.done, 0);
        tick();
        check("stall_done", bus.done, 1);
        check("stall_busy_total", busy_cnt, 11);
        tick();

        // Abort at step 9, then restart.
        bus.start = 1'b1; bus.last_idx = 5'd15;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        check("abort_idx9", bus.step_idx, 9);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_onehot", bus.step_onehot, 0);
        check("abort_idx", bus.step_idx, 0);
        check("abort_no_done", bus.done, 0);
        tick();
        check("abort_no_done2", bus.done, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("restart_busy", bus.busy, 1);
        check("restart_onehot", bus.step_onehot, 32'h1);
        // Abort together with start in IDLE: abort is ignored, start wins.
        bus.abort = 1'b1;
        tick();
        check("abort_run_busy", bus.busy, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("abort_idle_ignored", bus.busy, 1);
        tick();
        bus.abort = 1'b0;
        check("abort_again", bus.busy, 0);
        tick();

        // Start held high; last_idx changes mid-run.
        bus.start = 1'b1; bus.last_idx = 5'd3;
        tick();
        check("held_idx0", bus.step_idx, 0);
        bus.last_idx = 5'd1;
        tick();
        check("held_idx1", bus.step_idx, 1);
        check("held_not_last", bus.last, 0);
        tick();
        check("held_idx2", bus.step_idx, 2);
        tick();
        check("held_idx3_last", bus.last, 1);
        tick();
        check("held_done", bus.done, 1);
        check("held_gap", bus.busy, 0);
        tick();
        check("held_rerun_busy", bus.busy, 1);
        check("held_rerun_idx", bus.step_idx, 0);
        bus.start = 1'b0;
        tick();
        check("held_rerun_last", bus.last, 1);
        tick();
        check("held_rerun_done", bus.done, 1);
        tick();

        // Reset mid-sequence.
        bus.start = 1'b1; bus.last_idx = 5'd10;
        tick();
        bus.start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", bus.busy, 0);
        check("midrst_idx", bus.step_idx, 0);
        tick();
        check("midrst_no_done", bus.done, 0);

`ifdef STEP_DESCEND_EN
        bus.start = 1'b1; bus.last_idx = 5'd5; bus.descend = 1'b1;
        tick();
        bus.start = 1'b0; bus.descend = 1'b0;
        check("desc_idx5", bus.step_idx, 5);
        check("desc_onehot5", bus.step_onehot, 32'h20);
        check("desc_first", bus.first, 1);
        check("desc_not_last", bus.last, 0);
        for (int k = 4; k >= 0; k--) begin
            tick();
            exp_oh = 32'h1 << k;
            check("desc_onehot", bus.step_onehot, exp_oh);
            check("desc_last", bus.last, (k == 0) ? 32'd1 : 32'd0);
        end
        tick();
        check("desc_done", bus.done, 1);
        check("desc_idle", bus.busy, 0);
        tick();
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/onehot_step_sequencer.md
Name: onehot_step_sequencer

Overview:
- Parametrised, registered step generator for the iterative multiply/divide datapath.
- Sequences a SEL_W-bit step index through a programmable count and drives a full one-hot decode of that index, OUT_W = 2^SEL_W wide. The default is 5 -> 32, one hot line per iteration.
- Adds the start/busy/done handshake, stall and abort that the combinational step decoder lacks.
- Sits between the multdiv control FSM and the per-bit partial-product / shift-subtract enables.

Parameters:
- SEL_W, 5, step index width.
- OUT_W, 2**SEL_W, one-hot output width. Derived only; must not be overridden.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a sequence. Sampled only when busy=0.
- last_idx  input  SEL_W  final step index. Latched on an accepted start.
- stall  input  1  hold the current step while busy.
- abort  input  1  terminate the sequence immediately, with no done pulse.
- step_onehot  output  OUT_W  one-hot decode of step_idx while busy; all zeros otherwise.
- step_idx  output  SEL_W  current step index (registered).
- first  output  1  high while busy and on step 0.
- last  output  1  high while busy and step_idx == latched last_idx.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle pulse after the final step completes.

Behaviour:
- One clock; reset is synchronous and active-high, named reset, with clock named clock.
- Reset values:
  - state=IDLE, step_idx=0, latched last=0.
  - busy=0, done=0, step_onehot=0, first=0, last=0.
  - Reset mid-sequence returns to IDLE on the next edge. No done pulse.
- States: IDLE, RUN.
- IDLE:
  - busy=0, step_onehot all zero.
  - start=1 -> RUN; step_idx<=0; last_idx latched.
- RUN:
  - busy=1; step_onehot[step_idx]=1, all other bits 0.
  - The decode is driven from registered state only, so the output has no combinational path from any input.
- Advance: in RUN with stall=0 and abort=0:
  - If step_idx != latched last: step_idx<=step_idx+1.
  - Else: state<=IDLE, done<=1 for exactly one cycle, step_idx<=0.
- Stall: step_idx, step_onehot and state are held. Stall on the last step delays done.
- Abort:
  - Highest priority in RUN. Next edge -> IDLE, step_idx<=0, done stays 0.
  - Abort in IDLE has no effect.
- start while busy=1 is ignored, and last_idx is not re-latched.
- Back-to-back: start asserted in the cycle done=1 (state already IDLE) is accepted. RUN is re-entered with one idle cycle between sequences.
- Latency:
  - start accepted at edge t -> step 0 visible after t.
  - Step k visible after edge t+k, with no stalls.
  - done high after edge t+last+1, for one cycle.
- Boundary:
  - last_idx=0 -> single-step sequence: one RUN cycle with first=last=1, then done.
  - last_idx=OUT_W-1 -> the full sweep runs to the top bit; the counter never wraps.
- Arithmetic: unsigned SEL_W-bit counter. Increment never overflows because the count terminates at last <= OUT_W-1.

Optional Feature:
- Macro STEP_DESCEND_EN.
- When defined:
  - Adds input port descend (1 bit), sampled with an accepted start.
  - descend=1: step_idx starts at latched last and decrements to 0. done follows the step-0 cycle. first flags the starting step (last); last flags step 0.
  - descend=0: behaviour as above.
- When undefined: no descend port; ascending only. Logic must compile with no unused-signal warnings.

Test Plan:
- Reset then start=1, last_idx=31, no stall -> step_onehot walks 0x00000001..0x80000000 over 32 cycles; first only on cycle 1, last only on cycle 32; done=1 on cycle 33, then busy=0.
- last_idx=0, start pulse -> exactly one busy cycle with step_onehot=0x00000001, first=last=1; done on the next cycle.
- last_idx=7, stall=1 for 3 cycles at step_idx=4 -> step_onehot holds 0x00000010 for 4 cycles; done 3 cycles later than the unstalled run; total busy = 11 cycles.
- last_idx=15, abort at step_idx=9 -> next cycle busy=0, step_onehot=0, done never asserted. A start 1 cycle later restarts at step 0.
- start held high continuously, last_idx=3 -> sequences 0,1,2,3, done+IDLE, 0,1,2,3 repeating; changing last_idx mid-run to 1 has no effect on the current sequence.
- With STEP_DESCEND_EN, descend=1, last_idx=5 -> step_idx 5,4,3,2,1,0 (step_onehot 0x20 down to 0x01); done after step 0. SEL_W=3 build -> OUT_W=8 sweep correct.
